// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_CORES memory stages.
// One transaction in flight: IDLE -> ACCESS -> (WAIT) -> RESP -> IDLE.
module dmem_arbiter #(
  parameter int unsigned NUM_CORES    = 2,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CORES-1:0]    core_req_valid,
  input  logic [NUM_CORES-1:0]    core_req_we,
  input  logic [32*NUM_CORES-1:0] core_req_addr,
  input  logic [32*NUM_CORES-1:0] core_req_wdata,
  output logic [NUM_CORES-1:0]    core_req_ready,
  output logic [NUM_CORES-1:0]    core_resp_valid,
  output logic [31:0]             core_resp_rdata,
  output logic [31:0]             dmem_addr,
  output logic [31:0]             dmem_wdata,
  output logic                    dmem_read_en,
  output logic                    dmem_write_en,
  input  logic [31:0]             dmem_read_data
);

  localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] idx_q;
  logic [2:0]      cnt_q, cnt_d;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic            we_q;

  logic [IdxW-1:0] grant_idx;
  logic            grant_found;
  logic            accept;

  // Search from rr_ptr upward with wrap; first valid core wins.
  always_comb begin
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      cand     = (32'(rr_ptr_q) + k) % NUM_CORES;
      cand_idx = IdxW'(cand);
      if (!grant_found && core_req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign accept = (state_q == StIdle) && grant_found;

  always_comb begin
    core_req_ready = '0;
    if (accept) begin
      core_req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    core_resp_valid = '0;
    if (state_q == StResp) begin
      core_resp_valid[idx_q] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (grant_found) begin
          state_d  = StAccess;
          rr_ptr_d = (grant_idx == IdxW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      StAccess: begin
        if (we_q) begin
          state_d = StResp;
        end else begin
          cnt_d   = 3'(READ_LATENCY);
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      if (accept) begin
        addr_q  <= core_req_addr[32*grant_idx +: 32];
        wdata_q <= core_req_wdata[32*grant_idx +: 32];
        we_q    <= core_req_we[grant_idx];
        idx_q   <= grant_idx;
      end
      // Memory data is valid in the last WAIT cycle; rdata holds until the next read.
      if ((state_q == StWait) && (cnt_q == 3'd1)) begin
        rdata_q <= dmem_read_data;
      end
    end
  end

  assign dmem_addr       = addr_q;
  assign dmem_wdata      = wdata_q;
  assign dmem_read_en    = (state_q == StAccess) && !we_q;
  assign dmem_write_en   = (state_q == StAccess) && we_q;
  assign core_resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: transaction-level reference model, memory model,
// and a monitor that checks DMEM accesses and core responses against queued expectations.
module tb_dmem_arbiter;

  localparam int NC = 3;
  localparam int RL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]    valid, we;
  logic [31:0]      addr [NC];
  logic [31:0]      wdata [NC];
  logic [32*NC-1:0] addr_bus, wdata_bus;

  logic [NC-1:0] core_req_ready, core_resp_valid;
  logic [31:0]   core_resp_rdata, dmem_addr, dmem_wdata, dmem_read_data;
  logic          dmem_read_en, dmem_write_en;

  always_comb begin
    addr_bus  = '0;
    wdata_bus = '0;
    for (int i = 0; i < NC; i++) begin
      addr_bus[32*i +: 32]  = addr[i];
      wdata_bus[32*i +: 32] = wdata[i];
    end
  end

  dmem_arbiter #(
    .NUM_CORES    (NC),
    .READ_LATENCY (RL)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .core_req_valid  (valid),
    .core_req_we     (we),
    .core_req_addr   (addr_bus),
    .core_req_wdata  (wdata_bus),
    .core_req_ready  (core_req_ready),
    .core_resp_valid (core_resp_valid),
    .core_resp_rdata (core_resp_rdata),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_read_en    (dmem_read_en),
    .dmem_write_en   (dmem_write_en),
    .dmem_read_data  (dmem_read_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Memory model behind the arbiter: data valid RL cycles after the read_en cycle.
  logic [31:0] bus_mem [logic [31:0]];
  logic        pipe_v [RL];
  logic [31:0] pipe_d [RL];
  logic [31:0] junk = 32'h0BAD_0BAD;

  always @(posedge clk) begin
    pipe_v[0] <= dmem_read_en;
    pipe_d[0] <= bus_mem.exists(dmem_addr) ? bus_mem[dmem_addr] : init_val(dmem_addr);
    for (int i = 1; i < RL; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
    if (dmem_write_en) bus_mem[dmem_addr] = dmem_wdata;
    junk <= $urandom;
  end
  assign dmem_read_data = (pipe_v[RL-1] === 1'b1) ? pipe_d[RL-1] : junk;

  // Reference model: arbiter is free again 3 (write) or RL+3 (read) cycles after accept.
  typedef struct {int due; logic we; logic [31:0] addr; logic [31:0] wdata;} acc_t;
  typedef struct {int due; int core; logic we; logic [31:0] rdata;} rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  int          free_at = 0;
  int          ptr = 0;
  logic [NC-1:0] acc_pulse = '0;

  always @(negedge clk) begin
    logic [NC-1:0] exp_rdy;
    logic [31:0]   rd;
    int g, c;
    exp_rdy   = '0;
    acc_pulse = '0;
    if (!rst_n) begin
      ptr     = 0;
      free_at = 0;
      acc_q.delete();
      rsp_q.delete();
    end else begin
      if (cyc >= free_at && valid != '0) begin
        g = -1;
        for (int k = 0; k < NC; k++) begin
          c = (ptr + k) % NC;
          if (g < 0 && valid[c]) g = c;
        end
        exp_rdy[g]   = 1'b1;
        acc_pulse[g] = 1'b1;
        acc_q.push_back('{cyc + 1, we[g], addr[g], wdata[g]});
        if (we[g]) begin
          ref_mem[addr[g]] = wdata[g];
          rsp_q.push_back('{cyc + 2, g, 1'b1, 32'h0});
          free_at = cyc + 3;
        end else begin
          rd = ref_mem.exists(addr[g]) ? ref_mem[addr[g]] : init_val(addr[g]);
          rsp_q.push_back('{cyc + RL + 2, g, 1'b0, rd});
          free_at = cyc + RL + 3;
        end
        ptr = (g + 1) % NC;
      end
      check("ready", 32'(core_req_ready), 32'(exp_rdy));
    end
  end

  // Monitor: pops expectations whenever the DUT presents an access or a response.
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0;

  always @(negedge clk) begin
    acc_t a;
    rsp_t r;
    if (!rst_n) begin
      exp_addr  = '0;
      exp_wdata = '0;
      exp_rdata = '0;
      check("rst_ready", 32'(core_req_ready), 32'h0);
      check("rst_resp_valid", 32'(core_resp_valid), 32'h0);
      check("rst_read_en", 32'(dmem_read_en), 32'h0);
      check("rst_write_en", 32'(dmem_write_en), 32'h0);
      check("rst_dmem_addr", dmem_addr, 32'h0);
      check("rst_dmem_wdata", dmem_wdata, 32'h0);
      check("rst_rdata", core_resp_rdata, 32'h0);
    end else begin
      check("both_enables", 32'(dmem_read_en & dmem_write_en), 32'h0);
      while (acc_q.size() > 0 && acc_q[0].due < cyc) begin
        void'(acc_q.pop_front());
        flag_fail("access_missing");
      end
      if (dmem_read_en || dmem_write_en) begin
        if (acc_q.size() == 0) begin
          flag_fail("access_unexpected");
        end else begin
          a = acc_q.pop_front();
          check("access_cycle", cyc, a.due);
          check("access_we", 32'(dmem_write_en), 32'(a.we));
          exp_addr  = a.addr;
          exp_wdata = a.wdata;
        end
      end
      check("dmem_addr", dmem_addr, exp_addr);
      check("dmem_wdata", dmem_wdata, exp_wdata);
      while (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
        void'(rsp_q.pop_front());
        flag_fail("resp_missing");
      end
      if (core_resp_valid != '0) begin
        if (rsp_q.size() == 0) begin
          flag_fail("resp_unexpected");
        end else begin
          r = rsp_q.pop_front();
          check("resp_cycle", cyc, r.due);
          check("resp_core", 32'(core_resp_valid), 32'h1 << r.core);
          if (!r.we) exp_rdata = r.rdata;
        end
      end
      check("resp_rdata", core_resp_rdata, exp_rdata);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    valid[i] = 1'b1;
    we[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
  endtask

  task automatic wait_acc(input int i);
    for (int n = 0; n < 64; n++) begin
      step(1);
      if (acc_pulse[i]) begin
        valid[i] = 1'b0;
        return;
      end
    end
    valid[i] = 1'b0;
    flag_fail("accept_timeout");
  endtask

  task automatic rand_cycles(input int n, input int pct);
    for (int t = 0; t < n; t++) begin
      step(1);
      for (int i = 0; i < NC; i++) begin
        if (valid[i] && acc_pulse[i]) valid[i] = 1'b0;
        if (!valid[i] && $urandom_range(99) < pct) begin
          req(i, 1'($urandom_range(1)), 32'h40 + 32'($urandom_range(7)) * 4, $urandom);
        end
      end
    end
    valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    valid = '0;
    we    = '0;
    for (int i = 0; i < NC; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
    end
    bus_mem[32'h10] = 32'hDEAD_BEEF;
    ref_mem[32'h10] = 32'hDEAD_BEEF;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Directed: read, write, read-back of the written word.
    req(0, 1'b0, 32'h10, 32'h0);
    wait_acc(0);
    req(1, 1'b1, 32'h20, 32'h1234_5678);
    wait_acc(1);
    req(0, 1'b0, 32'h20, 32'h0);
    wait_acc(0);
    step(RL + 4);

    // Every core continuously requesting, then sparse random traffic.
    rand_cycles(60, 100);
    step(RL + 4);
    rand_cycles(300, 30);
    step(RL + 4);

    // Reset during WAIT abandons the read; pointer returns to core 0.
    req(2, 1'b0, 32'h10, 32'h0);
    wait_acc(2);
    step(1);
    rst_n = 1'b0;
    #1;
    check("async_rst_read_en", 32'(dmem_read_en), 32'h0);
    check("async_rst_addr", dmem_addr, 32'h0);
    check("async_rst_resp", 32'(core_resp_valid), 32'h0);
    step(2);
    rst_n = 1'b1;
    req(0, 1'b0, 32'h44, 32'h0);
    req(1, 1'b1, 32'h48, 32'hCAFE_F00D);
    req(2, 1'b1, 32'h4C, 32'h0F0F_0F0F);
    @(negedge clk);
    check("post_reset_grant", 32'(core_req_ready), 32'h1);
    wait_acc(0);
    wait_acc(1);
    wait_acc(2);
    step(RL + 4);

    // A short-lived request during another core's transaction is never served.
    req(1, 1'b0, 32'h48, 32'h0);
    wait_acc(1);
    req(0, 1'b1, 32'h50, 32'h5555_AAAA);
    step(1);
    valid[0] = 1'b0;
    step(RL + 6);

    check("access_queue_drained", 32'(acc_q.size()), 32'h0);
    check("resp_queue_drained", 32'(rsp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Round-robin arbiter that shares the single external data-memory port among NUM_CORES memory stages in the multi-core processor.
- Sits between each core's memory-stage DMEM outputs and the one data_memory instance.
- Accepts one request at a time over a valid/ready handshake and drives the DMEM read/write enables for exactly one cycle.
- Waits the fixed memory read latency, then returns a one-cycle response to the granted core.

Parameters:
- NUM_CORES, 2, number of requesting cores; legal range 2..8.
- READ_LATENCY, 1, cycles from the dmem_read_en cycle to valid dmem_read_data; legal range 1..7.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- core_req_valid  input  NUM_CORES  per-core request valid; must be held stable until accepted.
- core_req_we  input  NUM_CORES  per-core request is a write (1) or read (0).
- core_req_addr  input  32*NUM_CORES  per-core byte address; core i occupies bits [32*i+31:32*i].
- core_req_wdata  input  32*NUM_CORES  per-core store data; same packing as core_req_addr.
- core_req_ready  output  NUM_CORES  one-hot accept strobe.
- core_resp_valid  output  NUM_CORES  one-hot, one-cycle completion strobe for reads and writes.
- core_resp_rdata  output  32  read data; meaningful only while the matching core_resp_valid bit is high.
- dmem_addr  output  32  address to data memory.
- dmem_wdata  output  32  store data to data memory.
- dmem_read_en  output  1  read enable.
- dmem_write_en  output  1  write enable.
- dmem_read_data  input  32  data returned by data memory.

Behaviour:
- Reset values (while rst_n=0):
  - state=IDLE, rr_ptr=0, latency counter=0.
  - All outputs are 0: dmem_addr, dmem_wdata, dmem_read_en, dmem_write_en, core_resp_valid, core_resp_rdata.
  - core_req_ready=0.
- Reset asserted mid-transaction abandons it: no response is issued, and DMEM enables drop immediately.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - grant = first core with valid=1, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_CORES-1, 0, ...).
  - core_req_ready is combinational: 1 only on the grant bit, and only while in IDLE with at least one valid asserted.
  - Handshake occurs at the rising edge where valid and ready are both 1. On that edge:
    - register addr, wdata, we and the granted index;
    - rr_ptr <= (granted index + 1) mod NUM_CORES;
    - next state ACCESS.
  - If no core is valid, stay in IDLE; rr_ptr is unchanged.
- ACCESS (cycle T):
  - dmem_addr and dmem_wdata are driven from registered values.
  - dmem_write_en=we and dmem_read_en=~we, both high for exactly this one cycle.
  - Write: next state RESP.
  - Read: load counter with READ_LATENCY; next state WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where the counter equals 1 (cycle T+READ_LATENCY), capture dmem_read_data into core_resp_rdata; next state RESP.
  - Both enables are 0 throughout WAIT.
- RESP:
  - core_resp_valid = one-hot of the granted index for exactly one cycle; next state IDLE.
  - Read response appears in cycle T+READ_LATENCY+1; write response in cycle T+1.
  - core_resp_rdata holds its value until the next read capture. Writes leave it unchanged.
- Throughput and latency:
  - One transaction in flight; no new grant outside IDLE.
  - Minimum spacing is 3 cycles per write and READ_LATENCY+3 per read.
  - Best-case read: accept edge to response cycle is READ_LATENCY+2 cycles.
- Boundary cases:
  - A core dropping valid before acceptance is legal; no access occurs for it.
  - Valid held through RESP by an already-served core is treated as a new request in the next IDLE.
  - dmem_addr and dmem_wdata hold their last values outside ACCESS.
  - No alignment checking and no address decode; the address passes through unmodified.
  - Simultaneous requests from all cores are served in round-robin order; no core waits more than NUM_CORES-1 grants.

Test Plan:
- Reset, then a single read by core0 (addr 0x10, mem[0x10]=0xDEADBEEF, READ_LATENCY=1):
  - ready[0] high in IDLE; dmem_read_en high for 1 cycle with dmem_addr=0x10;
  - core_resp_valid=2'b01 with rdata=0xDEADBEEF exactly 3 cycles after the accept edge.
- Core1 write (addr 0x20, data 0x12345678):
  - dmem_write_en high for one cycle with the correct addr/wdata;
  - resp_valid[1] in the following cycle; a later read of 0x20 returns 0x12345678.
- Both cores assert valid continuously for 6 transactions:
  - grants alternate 0,1,0,1,0,1;
  - no cycle has read_en and write_en both high; no overlapping accesses.
- READ_LATENCY=3, with memory model data valid 3 cycles after read_en:
  - rdata is captured correctly; resp appears 5 cycles after accept;
  - enables stay low during WAIT.
- rst_n pulsed low during WAIT of a core0 read:
  - all outputs 0 immediately; no resp_valid after release;
  - the next request is granted from rr_ptr=0.
- Core0 raises valid for 1 cycle while a core1 transaction is in progress, then drops it:
  - core0 is never granted; no access is issued for it.
